mul_pipe: RTL and testbench

Parametrised, multi-cycle signed integer multiply pipeline for the execute stage, carrying the multiply-path result, zero flag, overflow flag and destination register through STAGES registered stages. It replaces the chain of fixed, purely combinational pass-through multiply stages with a single block that has real per-stage valid bits, stall and flush control. It also exports a busy mask of in-flight destinations for the hazard unit. The block sits between the operand-forwarding muxes and the write-back arbiter.

---
 rtl/mul_pipe.sv | 92 +++++++++
 tb/tb_mul_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe.sv
// Signed multiply pipeline: STAGES registered stages carrying product, dst and valid,
// with stall/flush control and a busy mask of in-flight destinations.
module mul_pipe #(
  parameter int unsigned REG_SIZE = 32,
  parameter int unsigned STAGES   = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [REG_SIZE-1:0] in_a,
  input  logic [REG_SIZE-1:0] in_b,
  input  logic [4:0]          in_dst,
  input  logic                stall,
  input  logic                flush,
  output logic                out_valid,
  output logic [REG_SIZE-1:0] m_result,
  output logic                zero,
  output logic                overflow,
  output logic [4:0]          dst,
  output logic [31:0]         busy_mask
);

  localparam int unsigned PW = 2 * REG_SIZE;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod_c;

  // Stages 1..STAGES-1 hold the full product; stage STAGES is the output register set.
  logic [PW-1:0]      prod_q [1:STAGES-1];
  logic [4:0]         dst_q  [1:STAGES-1];
  logic [STAGES-1:1]  vld_q;

  logic [PW-1:0]      last_prod;
  logic [REG_SIZE:0]  top_bits;
  logic               ovf_c;

  assign a_ext  = {{REG_SIZE{in_a[REG_SIZE-1]}}, in_a};
  assign b_ext  = {{REG_SIZE{in_b[REG_SIZE-1]}}, in_b};
  assign prod_c = a_ext * b_ext;

  assign last_prod = prod_q[STAGES-1];
  assign top_bits  = last_prod[PW-1:REG_SIZE-1];
  // Representable iff the sign bit of the low half is replicated through the high half.
  assign ovf_c     = ~((&top_bits) | ~(|top_bits));

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      vld_q <= '0;
      for (int unsigned i = 1; i < STAGES; i++) begin
        prod_q[i] <= '0;
        dst_q[i]  <= '0;
      end
      out_valid <= 1'b0;
      m_result  <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      dst       <= '0;
    end else if (!stall) begin
      vld_q[1]  <= in_valid;
      prod_q[1] <= in_valid ? prod_c : '0;
      dst_q[1]  <= in_valid ? in_dst : '0;
      for (int unsigned i = 2; i < STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        prod_q[i] <= prod_q[i-1];
        dst_q[i]  <= dst_q[i-1];
      end
      out_valid <= vld_q[STAGES-1];
      if (vld_q[STAGES-1]) begin
        m_result <= last_prod[REG_SIZE-1:0];
        zero     <= (last_prod[REG_SIZE-1:0] == '0);
        overflow <= ovf_c;
        dst      <= dst_q[STAGES-1];
      end else begin
        m_result <= '0;
        zero     <= 1'b0;
        overflow <= 1'b0;
        dst      <= '0;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (vld_q[i]) busy_mask[dst_q[i]] = 1'b1;
    end
    if (out_valid) busy_mask[dst] = 1'b1;
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: expected results queued at issue, popped at out_valid.
module tb_mul_pipe;

  localparam int unsigned STAGES = 5;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic [4:0]  d;
  } res_t;

  logic        clk, reset_n, in_valid, stall, flush;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_dst;
  logic        out_valid, zero, overflow;
  logic [31:0] m_result, busy_mask;
  logic [4:0]  dst;

  int   nvec  = 0;
  int   nfail = 0;
  res_t exp_q[$];

  mul_pipe #(.REG_SIZE(32), .STAGES(STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_dst(in_dst), .stall(stall), .flush(flush), .out_valid(out_valid),
    .m_result(m_result), .zero(zero), .overflow(overflow), .dst(dst),
    .busy_mask(busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(logic [31:0] a, logic [31:0] b, logic [4:0] d);
    res_t   m;
    longint p;
    longint lim;
    lim   = 64'sd2147483647;
    p     = longint'($signed(a)) * longint'($signed(b));
    m.res = p[31:0];
    m.z   = (p[31:0] == 32'd0);
    m.o   = (p > lim) || (p < (-lim - 1));
    m.d   = d;
    return m;
  endfunction

  function automatic res_t obs();
    return res_t'({m_result, zero, overflow, dst});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_dst   = d;
    exp_q.push_back(model(a, b, d));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    nvec++;
    if (obs() !== res_t'(0)) begin nfail++; $display("FAIL reset_outputs: got %h expected 0", obs()); end
    nvec++;
    if (busy_mask !== 32'd0) begin nfail++; $display("FAIL reset_busy: got %h expected 0", busy_mask); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int   first = 0;
    int   busy_cnt = 0;
    res_t e;
    issue(32'd7, -32'sd6, 5'd3);
    for (int c = 1; c <= STAGES + 4; c++) begin
      if (busy_mask[3]) busy_cnt++;
      if (out_valid === 1'b1) begin
        if (first == 0) first = c;
        e = exp_q.pop_front();
        nvec++;
        if (obs() !== e || m_result !== 32'hFFFFFFD6) begin
          nfail++; $display("FAIL basic_result: got %h expected %h", obs(), e);
        end
      end
      tick();
    end
    nvec++;
    if (first != STAGES) begin nfail++; $display("FAIL basic_latency: got %0d expected %0d", first, STAGES); end
    nvec++;
    if (busy_cnt != STAGES) begin nfail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cnt, STAGES); end
    nvec++;
    if (exp_q.size() != 0) begin nfail++; $display("FAIL basic_missing: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_corners();
    res_t e;
    issue(32'h7FFFFFFF, 32'd2, 5'd11);
    issue(32'h80000000, 32'hFFFFFFFF, 5'd12);
    issue(32'h00010000, 32'h00010000, 5'd13);
    issue(32'd0, 32'd5, 5'd14);
    issue(32'h80000000, 32'h80000000, 5'd15);
    for (int c = 1; c <= STAGES + 6; c++) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          nvec++; nfail++; $display("FAIL corner_extra: got dst %0d expected no output", dst);
        end else begin
          e = exp_q.pop_front();
          nvec++;
          if (obs() !== e) begin nfail++; $display("FAIL corner_result: got %h expected %h", obs(), e); end
        end
      end
      tick();
    end
    nvec++;
    if (exp_q.size() != 0) begin nfail++; $display("FAIL corner_missing: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    res_t        e;
    logic [31:0] peak = '0;
    int          first = 0;
    int          last = 0;
    int          cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      issue($urandom, $urandom, 5'(i));
      peak = peak | busy_mask;
    end
    for (int c = 1; c <= STAGES + 6; c++) begin
      peak = peak | busy_mask;
      if (out_valid === 1'b1) begin
        if (first == 0) first = c;
        last = c;
        cnt++;
        e = exp_q.pop_front();
        nvec++;
        if (obs() !== e) begin nfail++; $display("FAIL b2b_result: got %h expected %h", obs(), e); end
      end
      tick();
    end
    nvec++;
    if (cnt != 5 || last - first != 4) begin
      nfail++; $display("FAIL b2b_consecutive: got %0d outputs over %0d cycles expected 5 over 5", cnt, last - first + 1);
    end
    nvec++;
    if (peak !== 32'h3E) begin nfail++; $display("FAIL b2b_busy_peak: got %h expected 0000003e", peak); end
  endtask

  task automatic test_stall();
    res_t        e;
    res_t        snap_o;
    logic        snap_v;
    logic [31:0] snap_b;
    int          first = 0;
    int          cnt = 0;
    issue(32'd1234, 32'hFFFFFF00, 5'd20);
    issue(32'h00ABCDEF, 32'd77, 5'd21);
    snap_o = obs();
    snap_v = out_valid;
    snap_b = busy_mask;
    stall    = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'd9;
    in_b     = 32'd9;
    in_dst   = 5'd9;
    for (int s = 0; s < 3; s++) begin
      tick();
      nvec++;
      if (out_valid !== snap_v || obs() !== snap_o || busy_mask !== snap_b) begin
        nfail++;
        $display("FAIL stall_frozen: got v=%b %h busy=%h expected v=%b %h busy=%h",
                 out_valid, obs(), busy_mask, snap_v, snap_o, snap_b);
      end
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    for (int c = 4; c <= STAGES + 8; c++) begin
      nvec++;
      if (busy_mask[9] !== 1'b0) begin nfail++; $display("FAIL stall_ignored_offer: got busy %h expected bit9=0", busy_mask); end
      if (out_valid === 1'b1) begin
        if (first == 0) first = c;
        cnt++;
        if (exp_q.size() == 0) begin
          nvec++; nfail++; $display("FAIL stall_extra: got dst %0d expected no output", dst);
        end else begin
          e = exp_q.pop_front();
          nvec++;
          if (obs() !== e) begin nfail++; $display("FAIL stall_result: got %h expected %h", obs(), e); end
        end
      end
      tick();
    end
    nvec++;
    if (first != STAGES + 2 || cnt != 2) begin
      nfail++; $display("FAIL stall_latency: got first=%0d count=%0d expected first=%0d count=2", first, cnt, STAGES + 2);
    end
  endtask

  task automatic test_flush();
    int cnt = 0;
    issue(32'd3, 32'd4, 5'd6);
    issue(32'd5, 32'd6, 5'd7);
    issue(32'd7, 32'd8, 5'd8);
    flush    = 1'b1;
    stall    = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'd2;
    in_b     = 32'd2;
    in_dst   = 5'd10;
    tick();
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    nvec++;
    if (out_valid !== 1'b0) begin nfail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    nvec++;
    if (busy_mask !== 32'd0) begin nfail++; $display("FAIL flush_busy: got %h expected 0", busy_mask); end
    nvec++;
    if (obs() !== res_t'(0)) begin nfail++; $display("FAIL flush_outputs: got %h expected 0", obs()); end
    for (int c = 0; c < 2 * STAGES; c++) begin
      if (out_valid === 1'b1) cnt++;
      tick();
    end
    nvec++;
    if (cnt != 0) begin nfail++; $display("FAIL flush_leak: got %0d outputs expected 0", cnt); end
  endtask

  task automatic test_reset_mid();
    res_t e;
    int   first = 0;
    issue(32'd100, 32'd200, 5'd17);
    issue(32'd300, 32'd400, 5'd18);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    exp_q.delete();
    nvec++;
    if (out_valid !== 1'b0 || obs() !== res_t'(0) || busy_mask !== 32'd0) begin
      nfail++; $display("FAIL reset_mid_outputs: got v=%b %h busy=%h expected all 0", out_valid, obs(), busy_mask);
    end
    reset_n = 1'b1;
    issue(32'hFFFFFFFD, 32'hFFFFFFF9, 5'd31);
    for (int c = 1; c <= STAGES + 4; c++) begin
      if (out_valid === 1'b1) begin
        if (first == 0) first = c;
        if (exp_q.size() == 0) begin
          nvec++; nfail++; $display("FAIL reset_mid_extra: got dst %0d expected no output", dst);
        end else begin
          e = exp_q.pop_front();
          nvec++;
          if (obs() !== e) begin nfail++; $display("FAIL reset_mid_result: got %h expected %h", obs(), e); end
        end
      end
      tick();
    end
    nvec++;
    if (first != STAGES) begin nfail++; $display("FAIL reset_mid_latency: got %0d expected %0d", first, STAGES); end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_dst   = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
